// File: rtl/tep_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states, access owner,
// and the byte-lane enable helper used when decoding memory strobes.
package tep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Byte writes enable only the lane selected by address bit 0.
  function automatic logic [1:0] lane_be(input logic byte_wr, input logic a0);
    if (!byte_wr) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dma_deadline_mon.sv
// Counts how long a DMA request has waited for its ack and raises a sticky
// underrun flag once the wait reaches the deadline without an ack.
module dma_deadline_mon #(
  parameter int DEADLINE = 6
) (
  input  logic m_clock,
  input  logic p_reset,
  input  logic req,
  input  logic ack,
  input  logic clr,
  output logic underrun
);

  localparam int CW = $clog2(DEADLINE + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEADLINE);

  logic [CW-1:0] count_q, count_d;
  logic          flag_q, flag_d;
  logic          waiting;
  logic          hit;

  assign waiting = req && !ack;
  assign hit     = waiting && (count_q == LIMIT);

  // A miss in the same cycle as a clear wins so no underrun is ever lost.
  always_comb begin
    count_d = '0;
    flag_d  = flag_q;
    if (waiting) count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
    if (clr) flag_d = 1'b0;
    if (hit) flag_d = 1'b1;
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign underrun = flag_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main memory between the CPU and the VGA fetch DMA
// using fixed ISSUE/WAIT access pairs, DMA priority and forced alternation.
module mem_arbiter
  import tep_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DMA_DEADLINE = 6
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_wbyte,
  input  logic [ADDR_W-1:0] cpu_adrs,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_adrs,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_underrun,
  input  logic              underrun_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic              we_q, we_d;
  logic              wbyte_q, wbyte_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_cpu, grant_dma;

  // In WAIT the current owner is masked, so the other side wins if pending.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    adrs_d    = adrs_q;
    we_d      = we_q;
    wbyte_d   = wbyte_q;
    wdata_d   = wdata_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma_req)      grant_dma = 1'b1;
        else if (cpu_req) grant_cpu = 1'b1;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_CPU && dma_req)      grant_dma = 1'b1;
        else if (owner_q == OWN_DMA && cpu_req) grant_cpu = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_dma) begin
      state_d = ST_ISSUE;
      owner_d = OWN_DMA;
      adrs_d  = dma_adrs;
      we_d    = 1'b0;
      wbyte_d = 1'b0;
      wdata_d = '0;
    end else if (grant_cpu) begin
      state_d = ST_ISSUE;
      owner_d = OWN_CPU;
      adrs_d  = cpu_adrs;
      we_d    = cpu_we;
      wbyte_d = cpu_wbyte;
      wdata_d = cpu_wdata;
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_CPU;
      adrs_q  <= '0;
      we_q    <= 1'b0;
      wbyte_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      adrs_q  <= adrs_d;
      we_q    <= we_d;
      wbyte_q <= wbyte_d;
      wdata_q <= wdata_d;
    end
  end

  logic issue, in_wait, byte_wr;
  assign issue   = (state_q == ST_ISSUE);
  assign in_wait = (state_q == ST_WAIT);
  assign byte_wr = we_q && wbyte_q;

  // Memory strobes come only from registered state, never from the requests.
  assign mem_en    = issue;
  assign mem_we    = issue && we_q;
  assign mem_be    = issue ? lane_be(byte_wr, adrs_q[0]) : 2'b00;
  assign mem_adrs  = issue ? {adrs_q[ADDR_W-1:1], 1'b0} : '0;
  assign mem_wdata = !issue ? '0 : (byte_wr ? {(DATA_W/8){wdata_q[7:0]}} : wdata_q);

  assign cpu_ack   = in_wait && (owner_q == OWN_CPU);
  assign dma_ack   = in_wait && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dma_rdata = dma_ack ? mem_rdata : '0;

  dma_deadline_mon #(
    .DEADLINE(DMA_DEADLINE)
  ) u_deadline (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .req     (dma_req),
    .ack     (dma_ack),
    .clr     (underrun_clr),
    .underrun(dma_underrun)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with the default deadline
// drives a small memory model, a second with deadline 2 watches underruns.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReq = 1'b0, cpuWe = 1'b0, cpuWbyte = 1'b0;
  logic [15:0] cpuAdrs = '0, cpuWdata = '0;
  logic        dmaReq = 1'b0;
  logic [15:0] dmaAdrs = '0;
  logic        underrunClr = 1'b0;
  logic [15:0] memRdata = '0;

  logic        aCpuAck, aDmaAck, aUnderrun, aMemEn, aMemWe;
  logic [15:0] aCpuRdata, aDmaRdata, aMemAdrs, aMemWdata;
  logic [1:0]  aMemBe;
  logic        bCpuAck, bDmaAck, bUnderrun, bMemEn, bMemWe;
  logic [15:0] bCpuRdata, bDmaRdata, bMemAdrs, bMemWdata;
  logic [1:0]  bMemBe;

  int total = 0;
  int passed = 0;

  logic [15:0] mem [0:255];

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DMA_DEADLINE(6)) dutA (
    .m_clock(clock), .p_reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_wbyte(cpuWbyte),
    .cpu_adrs(cpuAdrs), .cpu_wdata(cpuWdata),
    .cpu_ack(aCpuAck), .cpu_rdata(aCpuRdata),
    .dma_req(dmaReq), .dma_adrs(dmaAdrs),
    .dma_ack(aDmaAck), .dma_rdata(aDmaRdata),
    .dma_underrun(aUnderrun), .underrun_clr(underrunClr),
    .mem_en(aMemEn), .mem_we(aMemWe), .mem_be(aMemBe),
    .mem_adrs(aMemAdrs), .mem_wdata(aMemWdata), .mem_rdata(memRdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DMA_DEADLINE(2)) dutB (
    .m_clock(clock), .p_reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_wbyte(cpuWbyte),
    .cpu_adrs(cpuAdrs), .cpu_wdata(cpuWdata),
    .cpu_ack(bCpuAck), .cpu_rdata(bCpuRdata),
    .dma_req(dmaReq), .dma_adrs(dmaAdrs),
    .dma_ack(bDmaAck), .dma_rdata(bDmaRdata),
    .dma_underrun(bUnderrun), .underrun_clr(underrunClr),
    .mem_en(bMemEn), .mem_we(bMemWe), .mem_be(bMemBe),
    .mem_adrs(bMemAdrs), .mem_wdata(bMemWdata), .mem_rdata(memRdata)
  );

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clock) begin
    if (aMemEn) begin
      if (aMemWe && aMemBe[0]) mem[aMemAdrs[8:1]][7:0]  <= aMemWdata[7:0];
      if (aMemWe && aMemBe[1]) mem[aMemAdrs[8:1]][15:8] <= aMemWdata[15:8];
      memRdata <= mem[aMemAdrs[8:1]];
    end
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h08] = 16'hBEEF;
    mem[8'h10] = 16'hA0A0;
    mem[8'h80] = 16'h1234;
    mem[8'h81] = 16'h5678;

    // Reset values
    applyStimulus(3);
    checkOutput("rst_mem_en", aMemEn, 0);
    checkOutput("rst_mem_we", aMemWe, 0);
    checkOutput("rst_mem_be", aMemBe, 0);
    checkOutput("rst_mem_adrs", aMemAdrs, 0);
    checkOutput("rst_mem_wdata", aMemWdata, 0);
    checkOutput("rst_acks", {aCpuAck, aDmaAck}, 0);
    checkOutput("rst_rdata", {aCpuRdata, aDmaRdata}, 0);
    checkOutput("rst_underrun", {aUnderrun, bUnderrun}, 0);
    reset = 1'b0;
    applyStimulus(1);

    // Single CPU read, then re-request to observe 3-cycle spacing
    cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(1);
    checkOutput("rd_c1_en", aMemEn, 1);
    checkOutput("rd_c1_adrs", aMemAdrs, 16'h0010);
    checkOutput("rd_c1_we_be", {aMemWe, aMemBe}, 3'b011);
    checkOutput("rd_c1_noack", aCpuAck, 0);
    applyStimulus(1);
    checkOutput("rd_c2_ack", aCpuAck, 1);
    checkOutput("rd_c2_rdata", aCpuRdata, 16'hBEEF);
    checkOutput("rd_c2_dmaack", aDmaAck, 0);
    applyStimulus(1);
    checkOutput("rd_c3_idle", aMemEn, 0);
    applyStimulus(1);
    checkOutput("rd_c4_en", aMemEn, 1);
    applyStimulus(1);
    checkOutput("rd_c5_ack", aCpuAck, 1);
    cpuReq = 1'b0;
    applyStimulus(1);

    // CPU byte write to the high lane
    cpuReq = 1'b1; cpuAdrs = 16'h0021; cpuWdata = 16'h0055; cpuWe = 1'b1; cpuWbyte = 1'b1;
    applyStimulus(1);
    checkOutput("bw_adrs", aMemAdrs, 16'h0020);
    checkOutput("bw_be", aMemBe, 2'b10);
    checkOutput("bw_wdata", aMemWdata, 16'h5555);
    checkOutput("bw_we", aMemWe, 1);
    applyStimulus(1);
    checkOutput("bw_ack", aCpuAck, 1);
    cpuReq = 1'b0; cpuWe = 1'b0; cpuWbyte = 1'b0; cpuWdata = '0;
    applyStimulus(1);
    cpuReq = 1'b1; cpuAdrs = 16'h0020;
    applyStimulus(2);
    checkOutput("bw_readback", aCpuRdata, 16'h55A0);
    cpuReq = 1'b0;
    applyStimulus(1);

    // Simultaneous requests: DMA first, then strict alternation
    dmaReq = 1'b1; dmaAdrs = 16'h0100; cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(1);
    checkOutput("sim_c1_adrs", aMemAdrs, 16'h0100);
    applyStimulus(1);
    checkOutput("sim_c2_acks", {aDmaAck, aCpuAck}, 2'b10);
    checkOutput("sim_c2_rdata", aDmaRdata, 16'h1234);
    applyStimulus(1);
    checkOutput("sim_c3_adrs", aMemAdrs, 16'h0010);
    applyStimulus(1);
    checkOutput("sim_c4_acks", {aDmaAck, aCpuAck}, 2'b01);
    checkOutput("sim_c4_rdata", aCpuRdata, 16'hBEEF);
    applyStimulus(1);
    checkOutput("sim_c5_adrs", aMemAdrs, 16'h0100);
    applyStimulus(1);
    checkOutput("sim_c6_acks", {aDmaAck, aCpuAck}, 2'b10);
    dmaReq = 1'b0; cpuReq = 1'b0;
    applyStimulus(1);
    checkOutput("sim_underrun_d6", aUnderrun, 0);
    checkOutput("sim_underrun_d2", bUnderrun, 1);
    underrunClr = 1'b1;
    applyStimulus(1);
    underrunClr = 1'b0;

    // CPU continuous, DMA raised during the CPU WAIT cycle
    cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(2);
    checkOutput("mid_c2_cpuack", aCpuAck, 1);
    dmaReq = 1'b1; dmaAdrs = 16'h0102;
    applyStimulus(1);
    checkOutput("mid_c3_dma_issue", {aMemEn, aMemAdrs}, {1'b1, 16'h0102});
    applyStimulus(1);
    checkOutput("mid_c4_dmaack", {aDmaAck, aDmaRdata}, {1'b1, 16'h5678});
    dmaReq = 1'b0;
    applyStimulus(1);
    checkOutput("mid_c5_cpu_issue", aMemAdrs, 16'h0010);
    applyStimulus(1);
    checkOutput("mid_c6_cpuack", aCpuAck, 1);
    cpuReq = 1'b0;
    applyStimulus(1);
    checkOutput("mid_no_underrun", {aUnderrun, bUnderrun}, 2'b00);

    // Deadline 2: DMA raised during CPU ISSUE misses its deadline
    cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(1);
    dmaReq = 1'b1; dmaAdrs = 16'h0100;
    applyStimulus(1);
    cpuReq = 1'b0;
    applyStimulus(1);
    checkOutput("dl_c3_not_yet", bUnderrun, 0);
    applyStimulus(1);
    checkOutput("dl_c4_dmaack", bDmaAck, 1);
    checkOutput("dl_c4_set", bUnderrun, 1);
    checkOutput("dl_c4_d6_clear", aUnderrun, 0);
    dmaReq = 1'b0;
    applyStimulus(1);
    checkOutput("dl_sticky", bUnderrun, 1);
    underrunClr = 1'b1;
    applyStimulus(1);
    underrunClr = 1'b0;
    checkOutput("dl_cleared", bUnderrun, 0);

    // Same miss again with the clear landing on the miss cycle
    cpuReq = 1'b1;
    applyStimulus(1);
    dmaReq = 1'b1;
    applyStimulus(1);
    cpuReq = 1'b0;
    applyStimulus(1);
    underrunClr = 1'b1;
    applyStimulus(1);
    underrunClr = 1'b0;
    checkOutput("dl_set_beats_clr", bUnderrun, 1);
    dmaReq = 1'b0;
    applyStimulus(1);

    // Reset coinciding with a CPU ISSUE: access reaches memory, no ack
    cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(1);
    checkOutput("rsti_en", aMemEn, 1);
    reset = 1'b1; cpuReq = 1'b0;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rsti_noack", {aCpuAck, aDmaAck}, 0);
    checkOutput("rsti_flag_cleared", bUnderrun, 0);
    applyStimulus(1);

    // Reset during WAIT of a CPU read, then a fresh request
    cpuReq = 1'b1; cpuAdrs = 16'h0010;
    applyStimulus(2);
    reset = 1'b1; cpuReq = 1'b0;
    applyStimulus(1);
    reset = 1'b0;
    checkOutput("rstw_outputs",
                {aMemEn, aMemWe, aMemBe, aMemAdrs, aMemWdata, aCpuAck, aDmaAck},
                '0);
    checkOutput("rstw_rdata", {aCpuRdata, aDmaRdata}, 0);
    applyStimulus(1);
    checkOutput("rstw_no_late_ack", {aCpuAck, aMemEn}, 0);
    cpuReq = 1'b1; cpuAdrs = 16'h0020;
    applyStimulus(1);
    checkOutput("rstw_fresh_c1", {aMemEn, aMemAdrs}, {1'b1, 16'h0020});
    applyStimulus(1);
    checkOutput("rstw_fresh_c2", {aCpuAck, aCpuRdata}, {1'b1, 16'h55A0});
    cpuReq = 1'b0;
    applyStimulus(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
